// File: rtl/reg_scoreboard.sv
// Write-pending register scoreboard: tracks in-flight destination registers with
// per-register latency counters and answers source-operand busy lookups for decode.
module reg_scoreboard #(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned LW   = 2,
    parameter int unsigned SCW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_dst,
    input  logic [LW-1:0]   issue_lat,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_dst,
    input  logic            kill,
    input  logic [AW-1:0]   rd_a,
    input  logic [AW-1:0]   rd_b,
    input  logic            use_a,
    input  logic            use_b,
    output logic            busy_a,
    output logic            busy_b,
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] busy_vec,
    output logic [SCW-1:0]  stall_cnt
);

    logic [LW-1:0]  cnt     [NREG];
    logic [LW-1:0]  cnt_nxt [NREG];
    logic           last_valid;
    logic [AW-1:0]  last_dst;
    logic [SCW-1:0] stall_cnt_nxt;

    // Lookup side: everything here is combinational from registered state.
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    assign busy_a     = busy_vec[rd_a];
    assign busy_b     = busy_vec[rd_b];
    assign stall      = (use_a & busy_a) | (use_b & busy_b);
    assign issue_fire = issue_valid & ~stall;

    // Per-register update: new issue beats writeback, which beats kill, which beats countdown.
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            cnt_nxt[i] = cnt[i];
            if (i == 0) begin
                cnt_nxt[i] = '0;
            end else if (issue_fire && (issue_dst == AW'(i)) && (issue_lat != '0)) begin
                cnt_nxt[i] = issue_lat;
            end else if (wb_valid && (wb_dst == AW'(i))) begin
                cnt_nxt[i] = '0;
            end else if (kill && last_valid && (last_dst == AW'(i))) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] != '0) begin
                cnt_nxt[i] = cnt[i] - LW'(1);
            end
        end
    end

    // Stall statistic saturates at all-ones.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (stall && (stall_cnt != '1)) begin
            stall_cnt_nxt = stall_cnt + SCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                cnt[i] <= '0;
            end
            last_valid <= 1'b0;
            last_dst   <= '0;
            stall_cnt  <= '0;
        end else begin
            cnt        <= cnt_nxt;
            last_valid <= issue_fire;
            if (issue_fire) begin
                last_dst <= issue_dst;
            end
            stall_cnt  <= stall_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, hand sequences,
// random traffic against a ready-time reference model, and stall counter saturation.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [2:0]  issue_dst;
    logic [1:0]  issue_lat;
    logic        wb_valid;
    logic [2:0]  wb_dst;
    logic        kill;
    logic [2:0]  rd_a;
    logic [2:0]  rd_b;
    logic        use_a;
    logic        use_b;
    logic        busy_a;
    logic        busy_b;
    logic        stall;
    logic        issue_fire;
    logic [7:0]  busy_vec;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    reg_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_lat(issue_lat),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .kill(kill),
        .rd_a(rd_a), .rd_b(rd_b), .use_a(use_a), .use_b(use_b),
        .busy_a(busy_a), .busy_b(busy_b), .stall(stall), .issue_fire(issue_fire),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int iv, dst, lat, wv, wd, kl, ra, rb, ua, ub;
        int bv, st, fi, sc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int iv, dst, lat, wv, wd, kl, ra, rb, ua, ub,
                       input int bv, st, fi, sc);
        vec_t v;
        v.iv = iv; v.dst = dst; v.lat = lat; v.wv = wv; v.wd = wd; v.kl = kl;
        v.ra = ra; v.rb = rb; v.ua = ua; v.ub = ub;
        v.bv = bv; v.st = st; v.fi = fi; v.sc = sc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int iv, dst, lat, wv, wd, kl, ra, rb, ua, ub);
        issue_valid = 1'(iv);
        issue_dst   = 3'(dst);
        issue_lat   = 2'(lat);
        wb_valid    = 1'(wv);
        wb_dst      = 3'(wd);
        kill        = 1'(kl);
        rd_a        = 3'(ra);
        rd_b        = 3'(rb);
        use_a       = 1'(ua);
        use_b       = 1'(ub);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each register holds the absolute cycle at which it stops being busy.
    longint ready [8];
    longint cyc;
    bit     m_lv;
    int     m_ld;
    int     m_sc;

    function automatic bit m_busy(input int i);
        return (i != 0) && (cyc < ready[i]);
    endfunction

    task automatic rand_cycle(input int rst);
        int iv, dst, lat, wv, wd, kl, ra, rb, ua, ub;
        bit ba, bb, st, fi;
        logic [7:0] bv;
        iv  = int'($urandom_range(0, 1));
        dst = int'($urandom_range(0, 7));
        lat = int'($urandom_range(0, 3));
        wv  = ($urandom_range(0, 3) == 0) ? 1 : 0;
        wd  = int'($urandom_range(0, 7));
        kl  = ($urandom_range(0, 4) == 0) ? 1 : 0;
        ra  = int'($urandom_range(0, 7));
        rb  = int'($urandom_range(0, 7));
        ua  = ($urandom_range(0, 2) != 0) ? 1 : 0;
        ub  = ($urandom_range(0, 2) != 0) ? 1 : 0;
        reset = 1'(rst);
        drive(iv, dst, lat, wv, wd, kl, ra, rb, ua, ub);
        for (int i = 0; i < 8; i++) bv[i] = m_busy(i);
        ba = m_busy(ra);
        bb = m_busy(rb);
        st = (ua != 0 && ba) || (ub != 0 && bb);
        fi = (iv != 0) && !st;
        @(negedge clk);
        chk($sformatf("rnd%0d busy_vec", cyc), 32'(busy_vec), 32'(bv));
        chk($sformatf("rnd%0d busy_a", cyc), 32'(busy_a), 32'(ba));
        chk($sformatf("rnd%0d busy_b", cyc), 32'(busy_b), 32'(bb));
        chk($sformatf("rnd%0d stall", cyc), 32'(stall), 32'(st));
        chk($sformatf("rnd%0d issue_fire", cyc), 32'(issue_fire), 32'(fi));
        chk($sformatf("rnd%0d stall_cnt", cyc), 32'(stall_cnt), 32'(m_sc));
        if (rst != 0) begin
            for (int i = 0; i < 8; i++) ready[i] = 0;
            m_lv = 1'b0;
            m_ld = 0;
            m_sc = 0;
        end else begin
            if (st && m_sc < 65535) m_sc++;
            for (int i = 1; i < 8; i++) begin
                if (fi && dst == i && lat != 0)      ready[i] = cyc + 1 + lat;
                else if (wv != 0 && wd == i)         ready[i] = cyc + 1;
                else if (kl != 0 && m_lv && m_ld == i) ready[i] = cyc + 1;
            end
            m_lv = fi;
            if (fi) m_ld = dst;
        end
        tick();
        cyc++;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 3, 5, 1, 1);
        tick();
        issue_valid = 1'b1;
        @(negedge clk);
        chk("reset busy_vec", 32'(busy_vec), 32'h00);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset issue_fire", 32'(issue_fire), 32'd1);
        chk("reset busy_a", 32'(busy_a), 32'd0);
        tick();
        reset = 1'b0;

        //  iv dst lat wv wd kl ra rb ua ub   bv    st fi sc
        add(1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0);  // load r3
        add(1, 1, 1, 0, 0, 0, 3, 0, 1, 0, 8'h08, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 3, 0, 1, 0, 8'h08, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0, 3, 0, 1, 0, 8'h00, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h02, 0, 0, 2);
        add(1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 2);  // r0 issue
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 2);
        add(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 2);  // WAW r2
        add(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 8'h04, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 2);
        add(1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 2);  // kill r5, r6 survives
        add(1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 8'h40, 0, 1, 2);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h60, 0, 0, 2);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h40, 0, 0, 2);
        add(1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 2);  // stale kill
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 0, 0, 2);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h20, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 2);
        add(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 2);  // wb vs issue r4
        add(1, 4, 2, 1, 4, 0, 0, 4, 0, 0, 8'h10, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 8'h10, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 8'h10, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3);
        add(1, 7, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 3);  // early wb r7
        add(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 8'h80, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3);
        add(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 3);  // kill + reissue r2
        add(1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 8'h04, 0, 1, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3);

        foreach (tbl[r]) begin
            drive(tbl[r].iv, tbl[r].dst, tbl[r].lat, tbl[r].wv, tbl[r].wd, tbl[r].kl,
                  tbl[r].ra, tbl[r].rb, tbl[r].ua, tbl[r].ub);
            @(negedge clk);
            chk($sformatf("row%0d busy_vec", r), 32'(busy_vec), 32'(tbl[r].bv));
            chk($sformatf("row%0d stall", r), 32'(stall), 32'(tbl[r].st));
            chk($sformatf("row%0d issue_fire", r), 32'(issue_fire), 32'(tbl[r].fi));
            chk($sformatf("row%0d stall_cnt", r), 32'(stall_cnt), 32'(tbl[r].sc));
            tick();
        end

        // Reset in the middle of pending work, with an issue on the reset edge
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 6, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst pre busy_vec", 32'(busy_vec), 32'h02);
        tick();
        reset = 1'b1;
        drive(1, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst during busy_vec", 32'(busy_vec), 32'h42);
        chk("midrst during stall_cnt", 32'(stall_cnt), 32'd3);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 6, 1, 1);
        @(negedge clk);
        chk("midrst post busy_vec", 32'(busy_vec), 32'h00);
        chk("midrst post stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst post stall", 32'(stall), 32'd0);
        tick();

        // Random traffic against the reference model
        cyc  = 0;
        m_lv = 1'b0;
        m_ld = 0;
        m_sc = 0;
        for (int i = 0; i < 8; i++) ready[i] = 0;
        rand_cycle(1);
        for (int n = 0; n < 1500; n++) begin
            rand_cycle(($urandom_range(0, 63) == 0) ? 1 : 0);
        end

        // Stall counter saturation: each 4-cycle period issues r1 lat=3 then stalls 3 cycles
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int p = 0; p < 21846; p++) begin
            drive(1, 1, 3, 0, 0, 0, 1, 0, 0, 0);
            if (p == 21844) begin
                @(negedge clk);
                chk("sat near stall_cnt", 32'(stall_cnt), 32'd65532);
            end
            tick();
            drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            for (int k = 0; k < 3; k++) tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat final stall_cnt", 32'(stall_cnt), 32'hFFFF);
        chk("sat final stall", 32'(stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
